// File: rtl/uart_rx_fifo_if.sv
// Drain-side port of uart_rx_fifo: head-of-FIFO entry, valid/ready pop handshake and fill level.
// The receiver drives through the master modport; the consumer uses the slave modport.
interface uart_rx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
);
  logic [DATA_BITS-1:0]              data_o;
  logic                              parity_err_o;
  logic                              frame_err_o;
  logic                              valid_o;
  logic                              ready_i;
  logic [$clog2(FIFO_DEPTH+1)-1:0]   level_o;

  modport master (
    output data_o, parity_err_o, frame_err_o, valid_o, level_o,
    input  ready_i
  );

  modport slave (
    input  data_o, parity_err_o, frame_err_o, valid_o, level_o,
    output ready_i
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver (data width, parity, stop bits, baud divisor) feeding a
// first-word-fall-through FIFO with per-entry parity/framing flags and a sticky overrun flag.
module uart_rx_fifo #(
  parameter int CLK_DIV    = 32,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rx_i,
  input  logic           rx_en_i,
  input  logic           clr_i,
  output logic           overrun_o,
  uart_rx_fifo_if.master drain
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = DATA_BITS + 2;

  localparam logic [CW-1:0] HALF_BIT = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Line synchroniser and falling-edge detect
  // ---------------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q, rx_prev_q;
  logic fall_edge;

  // NOTE: sequential state is always written with <= so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the synchroniser.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // A line held low after a bad stop bit produces no new edge, so a break yields one frame.
  assign fall_edge = rx_prev_q & ~rx_sync_q;

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [BW-1:0]     bit_cnt_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic              perr_q, ferr_q;
  logic              tick;

  logic start_det, sample_data, sample_parity, sample_stop, frame_push;

  assign tick = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (fall_edge && rx_en_i) state_d = S_START;
      S_START:  if (tick) state_d = rx_sync_q ? S_IDLE : S_DATA;
      S_DATA:   if (tick && bit_cnt_q == LAST_DATA)
                  state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (tick) state_d = S_STOP;
      S_STOP:   if (tick && bit_cnt_q == LAST_STOP) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    start_det     = (state_q == S_IDLE) && fall_edge && rx_en_i;
    sample_data   = (state_q == S_DATA) && tick;
    sample_parity = (state_q == S_PARITY) && tick;
    sample_stop   = (state_q == S_STOP) && tick;
    frame_push    = sample_stop && (bit_cnt_q == LAST_STOP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      if (start_det) begin
        cnt_q     <= HALF_BIT;
        bit_cnt_q <= '0;
        perr_q    <= 1'b0;
        ferr_q    <= 1'b0;
      end else if (state_q != S_IDLE) begin
        cnt_q <= tick ? FULL_BIT : cnt_q - CW'(1);
      end
      if (sample_data) begin
        shreg_q   <= {rx_sync_q, shreg_q[DATA_BITS-1:1]};
        bit_cnt_q <= (bit_cnt_q == LAST_DATA) ? '0 : bit_cnt_q + BW'(1);
      end
      if (sample_parity)
        perr_q <= ((^shreg_q) ^ rx_sync_q) != 1'(PARITY_ODD);
      if (sample_stop) begin
        bit_cnt_q <= bit_cnt_q + BW'(1);
        if (!rx_sync_q) ferr_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO (first-word fall-through)
  // ---------------------------------------------------------------------------
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          overrun_q;
  logic [EW-1:0] push_entry, head;
  logic          fifo_full, fifo_valid, do_push, do_pop;

  assign push_entry = {ferr_q | ~rx_sync_q, perr_q, shreg_q};
  assign fifo_full  = (level_q == LEVEL_FULL);
  assign fifo_valid = (level_q != '0);
  assign do_pop     = fifo_valid && drain.ready_i && !clr_i;
  assign do_push    = frame_push && !clr_i && (!fifo_full || do_pop);

  // NOTE: the storage array has no reset; entries are only observable once written,
  // and the head outputs are forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      if (frame_push && fifo_full && !do_pop) overrun_q <= 1'b1;
    end
  end

  always_comb begin
    head               = mem[rd_ptr_q];
    drain.data_o       = fifo_valid ? head[DATA_BITS-1:0] : '0;
    drain.parity_err_o = fifo_valid & head[DATA_BITS];
    drain.frame_err_o  = fifo_valid & head[DATA_BITS+1];
    drain.valid_o      = fifo_valid;
    drain.level_o      = level_q;
    overrun_o          = overrun_q;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: an 8N1 instance and an 8E1 instance share clock and reset;
// a vector table covers frame contents/flags, hand-written sequences cover the multi-cycle cases.
module tb_uart_rx_fifo;

  localparam int CLK_DIV = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;
  logic rx_en = 1'b1;
  logic clr = 1'b0;
  logic ovr_a, ovr_b;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(8)) bus_a ();
  uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(8)) bus_b ();

  uart_rx_fifo #(.CLK_DIV(CLK_DIV)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_i      (rx_a),
    .rx_en_i   (rx_en),
    .clr_i     (clr),
    .overrun_o (ovr_a),
    .drain     (bus_a)
  );

  uart_rx_fifo #(.CLK_DIV(CLK_DIV), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_i      (rx_b),
    .rx_en_i   (rx_en),
    .clr_i     (clr),
    .overrun_o (ovr_b),
    .drain     (bus_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    bit         on_b;
    logic [7:0] data;
    logic       par_bit;
    logic       stop_val;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_line(input bit on_b, input logic v);
    if (on_b) rx_b = v;
    else      rx_a = v;
  endtask

  // Called at a falling edge; holds the line value for whole bit periods.
  task automatic drive_bit(input bit on_b, input logic v, input int cycles);
    set_line(on_b, v);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_frame(input bit on_b, input logic [7:0] d, input logic par_bit,
                            input logic stop_val);
    logic [10:0] bits;
    int n;
    bits = '0;
    bits[8:1] = d;
    if (on_b) begin
      bits[9]  = par_bit;
      bits[10] = stop_val;
      n = 11;
    end else begin
      bits[9] = stop_val;
      n = 10;
    end
    for (int i = 0; i < n; i++) drive_bit(on_b, bits[i], CLK_DIV);
    set_line(on_b, 1'b1);
  endtask

  task automatic pop(input bit on_b);
    if (on_b) bus_b.ready_i = 1'b1;
    else      bus_a.ready_i = 1'b1;
    @(negedge clk);
    bus_a.ready_i = 1'b0;
    bus_b.ready_i = 1'b0;
  endtask

  task automatic head(input bit on_b, output logic [7:0] d, output logic pe, output logic fe,
                      output logic vld, output logic [3:0] lvl);
    if (on_b) begin
      d = bus_b.data_o; pe = bus_b.parity_err_o; fe = bus_b.frame_err_o;
      vld = bus_b.valid_o; lvl = bus_b.level_o;
    end else begin
      d = bus_a.data_o; pe = bus_a.parity_err_o; fe = bus_a.frame_err_o;
      vld = bus_a.valid_o; lvl = bus_a.level_o;
    end
  endtask

  initial begin
    logic [7:0] d;
    logic pe, fe, vld;
    logic [3:0] lvl;
    int cyc;

    vecs[0] = '{on_b: 1'b1, data: 8'h07, par_bit: 1'b0, stop_val: 1'b1, exp_perr: 1'b1, exp_ferr: 1'b0};
    vecs[1] = '{on_b: 1'b1, data: 8'h07, par_bit: 1'b1, stop_val: 1'b1, exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[2] = '{on_b: 1'b0, data: 8'h3C, par_bit: 1'b0, stop_val: 1'b0, exp_perr: 1'b0, exp_ferr: 1'b1};
    vecs[3] = '{on_b: 1'b0, data: 8'hA5, par_bit: 1'b0, stop_val: 1'b1, exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[4] = '{on_b: 1'b1, data: 8'hA5, par_bit: 1'b0, stop_val: 1'b1, exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[5] = '{on_b: 1'b1, data: 8'hC1, par_bit: 1'b0, stop_val: 1'b0, exp_perr: 1'b1, exp_ferr: 1'b1};

    bus_a.ready_i = 1'b0;
    bus_b.ready_i = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_valid", bus_a.valid_o, 1'b0);
    check("reset_level", bus_a.level_o, 4'd0);
    check("reset_data", bus_a.data_o, 8'h00);
    check("reset_flags", {bus_a.parity_err_o, bus_a.frame_err_o}, 2'b00);
    check("reset_overrun", ovr_a, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 0x65 with start-edge-to-valid latency bound.
    cyc = 0;
    fork
      send_frame(1'b0, 8'h65, 1'b0, 1'b1);
      begin
        while (!bus_a.valid_o && cyc < 400) begin
          @(negedge clk);
          cyc++;
        end
      end
    join
    checks++;
    if (cyc < 300 || cyc > 10 * CLK_DIV + 4) begin
      errors++;
      $display("FAIL latency_0x65: got %0d cycles, required 300..%0d", cyc, 10 * CLK_DIV + 4);
    end
    head(1'b0, d, pe, fe, vld, lvl);
    check("data_0x65", d, 8'h65);
    check("flags_0x65", {pe, fe}, 2'b00);
    check("level_0x65", lvl, 4'd1);
    pop(1'b0);
    check("empty_after_pop", bus_a.valid_o, 1'b0);

    // Start glitch: low for 8 cycles must not start a frame.
    drive_bit(1'b0, 1'b0, 8);
    drive_bit(1'b0, 1'b1, 3 * CLK_DIV);
    check("glitch_valid", bus_a.valid_o, 1'b0);
    check("glitch_level", bus_a.level_o, 4'd0);

    // Vector table: each frame followed by two idle bit times.
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].on_b, vecs[i].data, vecs[i].par_bit, vecs[i].stop_val);
      repeat (2 * CLK_DIV) @(negedge clk);
      head(vecs[i].on_b, d, pe, fe, vld, lvl);
      check($sformatf("vec%0d_valid", i), vld, 1'b1);
      check($sformatf("vec%0d_data", i), d, vecs[i].data);
      check($sformatf("vec%0d_perr", i), pe, vecs[i].exp_perr);
      check($sformatf("vec%0d_ferr", i), fe, vecs[i].exp_ferr);
      check($sformatf("vec%0d_level", i), lvl, 4'd1);
      pop(vecs[i].on_b);
      head(vecs[i].on_b, d, pe, fe, vld, lvl);
      check($sformatf("vec%0d_popped", i), vld, 1'b0);
    end

    // Start detection disabled: frame ignored.
    rx_en = 1'b0;
    send_frame(1'b0, 8'h11, 1'b0, 1'b1);
    repeat (CLK_DIV) @(negedge clk);
    check("rx_en_off_valid", bus_a.valid_o, 1'b0);
    rx_en = 1'b1;

    // Overrun: nine frames into an eight-entry FIFO without draining.
    for (int i = 0; i < 9; i++) send_frame(1'b0, 8'(i), 1'b0, 1'b1);
    repeat (CLK_DIV) @(negedge clk);
    check("ovr_level", bus_a.level_o, 4'd8);
    check("ovr_flag", ovr_a, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d_data", i), bus_a.data_o, 8'(i));
      pop(1'b0);
    end
    check("drained_valid", bus_a.valid_o, 1'b0);
    check("drained_level", bus_a.level_o, 4'd0);
    check("ovr_sticky", ovr_a, 1'b1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_overrun", ovr_a, 1'b0);

    // Reset in the middle of data bit 3 with one entry already buffered.
    send_frame(1'b0, 8'h77, 1'b0, 1'b1);
    repeat (CLK_DIV) @(negedge clk);
    check("pre_rst_level", bus_a.level_o, 4'd1);
    drive_bit(1'b0, 1'b0, CLK_DIV);        // start
    drive_bit(1'b0, 1'b0, CLK_DIV);        // d0 of 0x5A
    drive_bit(1'b0, 1'b1, CLK_DIV);        // d1
    drive_bit(1'b0, 1'b0, CLK_DIV);        // d2
    drive_bit(1'b0, 1'b1, CLK_DIV / 2);    // first half of d3
    rst_n = 1'b0;
    set_line(1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("mid_rst_valid", bus_a.valid_o, 1'b0);
    check("mid_rst_level", bus_a.level_o, 4'd0);
    check("mid_rst_data", bus_a.data_o, 8'h00);
    rst_n = 1'b1;
    repeat (12 * CLK_DIV) @(negedge clk);
    check("post_rst_no_entry", bus_a.valid_o, 1'b0);
    send_frame(1'b0, 8'h5A, 1'b0, 1'b1);
    repeat (CLK_DIV) @(negedge clk);
    check("post_rst_data", bus_a.data_o, 8'h5A);
    check("post_rst_flags", {bus_a.parity_err_o, bus_a.frame_err_o}, 2'b00);
    check("post_rst_level", bus_a.level_o, 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
